// File: rtl/demand_pkg.sv
// Shared channel indices and sizing constants for the intersection demand detector.
package demand_pkg;

    localparam int N_CAR       = 4;
    localparam int N_PED       = 2;
    localparam int N_CHAN      = N_PED + N_CAR;
    localparam int TICKS_PER_S = 1000;

    localparam int SS_STRAIGHT = 0;
    localparam int SS_TURN     = 1;
    localparam int CS_STRAIGHT = 2;
    localparam int CS_TURN     = 3;
    localparam int PED_SS      = 0;
    localparam int PED_CS      = 1;

endpackage

// File: rtl/debounce_filter.sv
// One input channel: 2-flop synchroniser, then a tick-driven counter that flips the
// filtered state only after DEBOUNCE_MS consecutive ticks of disagreement.
module debounce_filter #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic raw_i,
    output logic filtered_o
);

    localparam int             CW   = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_MS - 1);

    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path infers a latch.
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (sync2_q == filt_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == LAST) begin
                filt_d = ~filt_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filtered_o = filt_q;

endmodule

// File: rtl/demand_detector.sv
// Debounces ped buttons and car sensors and latches per-phase demand until cleared.
// Optional stuck-sensor recall is built when STUCK_DETECT_EN is defined.
module demand_detector
    import demand_pkg::*;
#(
    parameter int CLK_HZ      = 1000,
    parameter int DEBOUNCE_MS = 20,
    parameter int CAR_HOLD_MS = 500,
    parameter int STUCK_S     = 300
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_PED-1:0] ped_btn_raw,
    input  logic [N_CAR-1:0] car_sensor_raw,
    input  logic [N_PED-1:0] ped_clear,
    input  logic [N_CAR-1:0] car_clear,
    output logic [N_PED-1:0] ped_demand,
    output logic [N_CAR-1:0] car_demand,
    output logic [N_CAR-1:0] car_present,
    output logic             any_demand,
    output logic [N_CAR-1:0] stuck_fault
);

    localparam int            TICK_DIV  = (CLK_HZ >= 2000) ? CLK_HZ / 1000 : 1;
    localparam int            HW        = $clog2(CAR_HOLD_MS + 1);
    localparam logic [HW-1:0] HOLD_DONE = HW'(CAR_HOLD_MS);

    logic tick;

    if (TICK_DIV > 1) begin : g_presc
        localparam int            PW       = $clog2(TICK_DIV);
        localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
        logic [PW-1:0] presc_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                  presc_q <= '0;
            else if (presc_q == PRE_LAST) presc_q <= '0;
            else                         presc_q <= presc_q + 1'b1;
        end
        assign tick = (presc_q == PRE_LAST);
    end else begin : g_no_presc
        assign tick = 1'b1;
    end

    logic [N_CHAN-1:0] raw_all, filt_all;
    assign raw_all = {car_sensor_raw, ped_btn_raw};

    for (genvar ch = 0; ch < N_CHAN; ch++) begin : g_chan
        debounce_filter #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_filt (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick_i     (tick),
            .raw_i      (raw_all[ch]),
            .filtered_o (filt_all[ch])
        );
    end

    logic [N_PED-1:0] ped_filt;
    assign ped_filt    = filt_all[N_PED-1:0];
    assign car_present = filt_all[N_CHAN-1:N_PED];

    logic [N_PED-1:0] ped_prev_q, ped_demand_q, ped_demand_d;
    logic [N_CAR-1:0] car_demand_q, car_demand_d, car_clear_eff;
    logic [N_CAR-1:0] stuck_q, stuck_d;
    logic [HW-1:0]    hold_q [N_CAR];
    logic [HW-1:0]    hold_d [N_CAR];
    logic             any_q;

`ifdef STUCK_DETECT_EN
    localparam int             MSW      = $clog2(TICKS_PER_S);
    localparam int             SW       = $clog2(STUCK_S + 1);
    localparam logic [MSW-1:0] MS_LAST  = MSW'(TICKS_PER_S - 1);
    localparam logic [SW-1:0]  SEC_DONE = SW'(STUCK_S);

    logic [MSW-1:0] ms_q  [N_CAR];
    logic [MSW-1:0] ms_d  [N_CAR];
    logic [SW-1:0]  sec_q [N_CAR];
    logic [SW-1:0]  sec_d [N_CAR];

    always_comb begin
        for (int i = 0; i < N_CAR; i++) begin
            ms_d[i]  = ms_q[i];
            sec_d[i] = sec_q[i];
            if (!car_present[i]) begin
                ms_d[i]  = '0;
                sec_d[i] = '0;
            end else if (tick && sec_q[i] != SEC_DONE) begin
                if (ms_q[i] == MS_LAST) begin
                    ms_d[i]  = '0;
                    sec_d[i] = sec_q[i] + 1'b1;
                end else begin
                    ms_d[i] = ms_q[i] + 1'b1;
                end
            end
            stuck_d[i] = stuck_q[i] | (sec_d[i] == SEC_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CAR; i++) begin
                ms_q[i]  <= '0;
                sec_q[i] <= '0;
            end
            stuck_q <= '0;
        end else begin
            ms_q    <= ms_d;
            sec_q   <= sec_d;
            stuck_q <= stuck_d;
        end
    end
`else
    assign stuck_q = '0;
    assign stuck_d = '0;
`endif

    // A stuck sensor keeps its lane recalled; the controller cannot clear it.
    assign car_clear_eff = car_clear & ~stuck_q;

    always_comb begin
        ped_demand_d = (ped_filt & ~ped_prev_q) | (ped_demand_q & ~ped_clear);
        for (int i = 0; i < N_CAR; i++) begin
            hold_d[i]       = hold_q[i];
            car_demand_d[i] = car_demand_q[i] | (hold_q[i] == HOLD_DONE);
            if (car_clear_eff[i]) begin
                car_demand_d[i] = 1'b0;
                hold_d[i]       = '0;
            end else if (!car_present[i]) begin
                hold_d[i] = '0;
            end else if (tick && hold_q[i] != HOLD_DONE) begin
                hold_d[i] = hold_q[i] + 1'b1;
            end
            if (stuck_d[i]) car_demand_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_prev_q   <= '0;
            ped_demand_q <= '0;
            car_demand_q <= '0;
            any_q        <= 1'b0;
            // NOTE: the hold counters are a small register array whose progress must be lost on reset, so each entry is reset.
            for (int i = 0; i < N_CAR; i++) hold_q[i] <= '0;
        end else begin
            ped_prev_q   <= ped_filt;
            ped_demand_q <= ped_demand_d;
            car_demand_q <= car_demand_d;
            any_q        <= |{ped_demand_q, car_demand_q};
            hold_q       <= hold_d;
        end
    end

    assign ped_demand  = ped_demand_q;
    assign car_demand  = car_demand_q;
    assign any_demand  = any_q;
    assign stuck_fault = stuck_q;

endmodule

// File: tb/tb_demand_detector.sv
// Bench for demand_detector: directed timing checks plus randomized traffic compared
// every cycle against a window-based behavioural model of the debounce/demand rules.
module tb_demand_detector;
    import demand_pkg::*;

    localparam int DW   = 20;
    localparam int HOLD = 500;
    localparam int STK  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_PED-1:0] ped_btn_raw, ped_clear, ped_demand;
    logic [N_CAR-1:0] car_sensor_raw, car_clear, car_demand, car_present, stuck_fault;
    logic             any_demand;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    demand_detector #(.CLK_HZ(1000), .DEBOUNCE_MS(DW), .CAR_HOLD_MS(HOLD), .STUCK_S(STK)) dut (
        .clk(clk), .rst_n(rst_n), .ped_btn_raw(ped_btn_raw), .car_sensor_raw(car_sensor_raw),
        .ped_clear(ped_clear), .car_clear(car_clear), .ped_demand(ped_demand),
        .car_demand(car_demand), .car_present(car_present), .any_demand(any_demand),
        .stuck_fault(stuck_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Model: a channel's filtered value flips when the last DW synchronised samples
    // (raw delayed by two edges) all disagree with it; demand flags follow the latch rules.
    bit              hist [N_CHAN][DW+1];
    bit [N_CHAN-1:0] m_filt, raw_now, f_old, nf;
    bit [N_PED-1:0]  m_pprev, m_ped, ped_old;
    bit [N_CAR-1:0]  m_car, car_old, m_stuck, stuck_new;
    bit              m_any, all_diff;
    int              m_run [N_CAR];
    int              m_pt  [N_CAR];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < N_CHAN; ch++)
                for (int k = 0; k <= DW; k++) hist[ch][k] = 1'b0;
            m_filt = '0; m_pprev = '0; m_ped = '0; m_car = '0; m_stuck = '0; m_any = 1'b0;
            for (int i = 0; i < N_CAR; i++) begin
                m_run[i] = 0;
                m_pt[i]  = 0;
            end
        end else begin
            raw_now = {car_sensor_raw, ped_btn_raw};
            f_old   = m_filt;
            nf      = m_filt;
            ped_old = m_ped;
            car_old = m_car;
            for (int ch = 0; ch < N_CHAN; ch++) begin
                all_diff = 1'b1;
                for (int k = 1; k <= DW; k++) if (hist[ch][k] == f_old[ch]) all_diff = 1'b0;
                if (all_diff) nf[ch] = ~f_old[ch];
                for (int k = DW; k >= 1; k--) hist[ch][k] = hist[ch][k-1];
                hist[ch][0] = raw_now[ch];
            end
            m_ped   = (f_old[N_PED-1:0] & ~m_pprev) | (ped_old & ~ped_clear);
            m_pprev = f_old[N_PED-1:0];
            stuck_new = m_stuck;
`ifdef STUCK_DETECT_EN
            for (int i = 0; i < N_CAR; i++) begin
                if (!f_old[N_PED+i])                   m_pt[i] = 0;
                else if (m_pt[i] < STK * TICKS_PER_S)  m_pt[i] = m_pt[i] + 1;
                if (m_pt[i] == STK * TICKS_PER_S) stuck_new[i] = 1'b1;
            end
`endif
            for (int i = 0; i < N_CAR; i++) begin
                if (car_clear[i] && !m_stuck[i]) begin
                    m_car[i] = 1'b0;
                    m_run[i] = 0;
                end else begin
                    m_car[i] = car_old[i] | (m_run[i] >= HOLD);
                    m_run[i] = f_old[N_PED+i] ? ((m_run[i] < HOLD) ? m_run[i] + 1 : HOLD) : 0;
                end
                if (stuck_new[i]) m_car[i] = 1'b1;
            end
            m_stuck = stuck_new;
            m_any   = (|ped_old) | (|car_old);
            m_filt  = nf;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_ped_demand",  ped_demand,  m_ped);
            check("cyc_car_demand",  car_demand,  m_car);
            check("cyc_car_present", car_present, m_filt[N_CHAN-1:N_PED]);
            check("cyc_any_demand",  any_demand,  m_any);
            check("cyc_stuck_fault", stuck_fault, m_stuck);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run still active at t=%0t, expected finish earlier", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        ped_btn_raw = '0; car_sensor_raw = '0; ped_clear = '0; car_clear = '0;
        @(negedge clk);
        chk_en = 1'b1;
        step(2);
        check("rst_ped", ped_demand, 0);
        check("rst_car", car_demand, 0);
        check("rst_pres", car_present, 0);
        check("rst_any", any_demand, 0);
        rst_n = 1'b1;

        // Clean press: demand at edge 23, any_demand at 24; held button never re-sets after clear.
        ped_btn_raw[PED_SS] = 1'b1;
        step(22); check("t1_ped_c22", ped_demand[PED_SS], 0);
        step(1);  check("t1_ped_c23", ped_demand[PED_SS], 1);
        check("t1_model_c23", m_ped[PED_SS], 1);
        check("t1_any_c23", any_demand, 0);
        step(1);  check("t1_any_c24", any_demand, 1);
        step(40);
        ped_clear[PED_SS] = 1'b1; step(1); ped_clear = '0;
        check("t1_clear", ped_demand[PED_SS], 0);
        step(35); check("t1_held_no_reset", ped_demand[PED_SS], 0);
        ped_btn_raw[PED_SS] = 1'b0;
        step(30);

        // Bouncing cross-street button never qualifies.
        for (int k = 0; k < 8; k++) begin
            ped_btn_raw[PED_CS] = (k % 2 == 0);
            step(5);
        end
        ped_btn_raw[PED_CS] = 1'b0;
        step(30); check("t2_bounce", ped_demand[PED_CS], 0);

        // Car presence at 22; sensor dropped at 300 gives no demand; full dwell gives demand at 523.
        car_sensor_raw[CS_STRAIGHT] = 1'b1;
        step(21); check("t3_pres_c21", car_present[CS_STRAIGHT], 0);
        step(1);  check("t3_pres_c22", car_present[CS_STRAIGHT], 1);
        step(278); car_sensor_raw[CS_STRAIGHT] = 1'b0;
        step(300); check("t3_short_dwell", car_demand[CS_STRAIGHT], 0);
        car_sensor_raw[CS_STRAIGHT] = 1'b1;
        step(522); check("t3_dem_c522", car_demand[CS_STRAIGHT], 0);
        step(1);   check("t3_dem_c523", car_demand[CS_STRAIGHT], 1);
        check("t3_model_c523", m_car[CS_STRAIGHT], 1);
        car_sensor_raw[CS_STRAIGHT] = 1'b0;

        // Clear with sensor held: re-dwell of 501 cycles; clear coincident with qualification wins.
        car_sensor_raw[CS_TURN] = 1'b1;
        step(523); check("t4_dem", car_demand[CS_TURN], 1);
        car_clear[CS_TURN] = 1'b1; step(1); car_clear = '0;
        check("t4_clear", car_demand[CS_TURN], 0);
        step(500); check("t4_c500", car_demand[CS_TURN], 0);
        car_clear[CS_TURN] = 1'b1; step(1); car_clear = '0;
        check("t4_clear_wins", car_demand[CS_TURN], 0);
        step(500); check("t4_c500_again", car_demand[CS_TURN], 0);
        step(1);   check("t4_reassert", car_demand[CS_TURN], 1);
        car_clear = 4'b1111; step(1); car_clear = '0;
        check("t4_multi_clear", car_demand, 4'b0000);
        car_sensor_raw[CS_TURN] = 1'b0;
        step(30);

        // Ped clear coincident with a new filtered edge: set wins.
        ped_btn_raw[PED_SS] = 1'b1;
        step(22);
        ped_clear[PED_SS] = 1'b1; step(1); ped_clear = '0;
        check("t5_set_wins", ped_demand[PED_SS], 1);
        ped_btn_raw[PED_SS] = 1'b0;
        step(30);
        ped_clear[PED_SS] = 1'b1; step(1); ped_clear = '0;

        // Reset mid-hold discards all progress.
        car_sensor_raw[SS_TURN] = 1'b1;
        step(300);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_pres", car_present, 0);
        check("rstmid_ped", ped_demand, 0);
        check("rstmid_car", car_demand, 0);
        check("rstmid_any", any_demand, 0);
        @(negedge clk); rst_n = 1'b1;
        step(522); check("rstmid_c522", car_demand[SS_TURN], 0);
        step(1);   check("rstmid_c523", car_demand[SS_TURN], 1);
        car_sensor_raw[SS_TURN] = 1'b0;
        car_clear[SS_TURN] = 1'b1; step(1); car_clear = '0;
        step(30);

`ifdef STUCK_DETECT_EN
        car_sensor_raw[SS_STRAIGHT] = 1'b1;
        step(2021); check("t6_stuck_c2021", stuck_fault[SS_STRAIGHT], 0);
        step(1);    check("t6_stuck_c2022", stuck_fault[SS_STRAIGHT], 1);
        car_clear[SS_STRAIGHT] = 1'b1; step(1); car_clear = '0;
        check("t6_clear_ignored", car_demand[SS_STRAIGHT], 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_stuck", stuck_fault, 0);
        check("t6_rst_car", car_demand, 0);
        @(negedge clk); rst_n = 1'b1;
        car_sensor_raw[SS_STRAIGHT] = 1'b0;
        step(30);
`endif

        // Randomized traffic, clears and occasional async resets, checked by the model each cycle.
        for (int c = 0; c < 15000; c++) begin
            @(negedge clk);
            for (int p = 0; p < N_PED; p++)
                if ($urandom_range(59) == 0) ped_btn_raw[p] = ~ped_btn_raw[p];
            for (int i = 0; i < N_CAR; i++) begin
                if ($urandom_range(299) == 0) car_sensor_raw[i] = ~car_sensor_raw[i];
                car_clear[i] = ($urandom_range(249) == 0);
            end
            for (int p = 0; p < N_PED; p++) ped_clear[p] = ($urandom_range(99) == 0);
            if ($urandom_range(3999) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        ped_clear = '0; car_clear = '0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
